// File: rtl/mem_stream_bridge.sv
// rtl/mem_stream_bridge.sv - byte stream <-> word memory bridge (load packs, dump unpacks)
// Optional MEM_BRIDGE_CHECKSUM_EN: XOR checksum byte after dump, load-side XOR on checksum_out.
module mem_stream_bridge #(
    parameter int WORD_WIDTH   = 32,
    parameter int DEPTH        = 25251,
    parameter int ADDR_WIDTH   = $clog2(DEPTH),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  dump_en_in,
    input  logic [ADDR_WIDTH:0]   dump_len_in,
    input  logic                  rx_valid_in,
    input  logic [7:0]            rx_byte_in,
    output logic                  wr_en_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out,
    output logic [WORD_WIDTH-1:0] wr_data_out,
    output logic [ADDR_WIDTH-1:0] rd_addr_out,
    input  logic [WORD_WIDTH-1:0] rd_data_in,
    output logic [7:0]            tx_byte_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in,
    output logic [ADDR_WIDTH:0]   load_count_out,
    output logic                  overflow_out,
`ifdef MEM_BRIDGE_CHECKSUM_EN
    output logic [7:0]            checksum_out,
`endif
    output logic                  dump_done_out
);
    localparam int BPW   = WORD_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(BPW - 1);
    localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(READ_LATENCY);
    localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_ACK, S_DONE} state_t;

    logic [IDX_W-1:0]      r_idx;
    logic [WORD_WIDTH-1:0] r_pack;
    logic [ADDR_WIDTH:0]   r_load_count;
    logic                  r_overflow;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WORD_WIDTH-1:0] r_wr_data;
    logic                  r_dump_en_d;
    logic                  w_restart;
    logic                  w_accept;
    logic                  w_word_done;
    logic [ADDR_WIDTH:0]   w_count;
    logic [WORD_WIDTH-1:0] w_word;

    state_t                r_state;
    state_t                w_next;
    logic                  w_trigger;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [LAT_W-1:0]      r_lat;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [ADDR_WIDTH:0]   r_words;
    logic                  r_ack_first;
    logic [ADDR_WIDTH:0]   w_eff_len;
    logic                  w_last_byte;
    logic                  w_last_word;
`ifdef MEM_BRIDGE_CHECKSUM_EN
    logic [7:0]            r_load_xor;
    logic [7:0]            r_dump_xor;
    logic                  r_cks_phase;
`endif

    // A falling dump_en_in starts a fresh load; a byte in that same cycle lands at count 0.
    assign w_restart   = r_dump_en_d && !dump_en_in;
    assign w_accept    = rx_valid_in && !dump_en_in;
    assign w_word_done = w_accept && (r_idx == LAST_IDX);
    assign w_count     = w_restart ? '0 : r_load_count;

    always_comb begin
        w_word = r_pack;
        for (int b = 0; b < BPW; b++) begin
            if (IDX_W'(b) == r_idx) w_word[b*8 +: 8] = rx_byte_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_idx        <= '0;
            r_pack       <= '0;
            r_load_count <= '0;
            r_overflow   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_dump_en_d  <= 1'b0;
        end else begin
            r_dump_en_d <= dump_en_in;
            r_wr_en     <= 1'b0;
            if (w_restart) begin
                r_load_count <= '0;
                r_overflow   <= 1'b0;
            end
            if (dump_en_in) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_pack <= w_word;
                if (w_word_done) begin
                    r_idx <= '0;
                    if (w_count == CNT_DEPTH) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= w_count[ADDR_WIDTH-1:0];
                        r_wr_data    <= w_word;
                        r_load_count <= w_count + 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

`ifdef MEM_BRIDGE_CHECKSUM_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)         r_load_xor <= '0;
        else if (w_restart) r_load_xor <= w_accept ? rx_byte_in : 8'h00;
        else if (w_accept)  r_load_xor <= r_load_xor ^ rx_byte_in;
    end
    assign checksum_out = r_load_xor;
`endif

    assign w_eff_len   = (dump_len_in == '0 || dump_len_in > CNT_DEPTH) ? CNT_DEPTH : dump_len_in;
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_last_word = (r_words + 1'b1 == w_eff_len);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Trigger is gated by busy and dump_en_in in the same cycle so an abort can never emit a byte.
    always_comb begin
        w_next    = r_state;
        w_trigger = 1'b0;
        if (!dump_en_in) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_next = S_FETCH;
                S_FETCH: if (r_lat == LAT_LAST) w_next = S_SEND;
                S_SEND: begin
                    if (!tx_busy_in) begin
                        w_trigger = 1'b1;
                        w_next    = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!r_ack_first && !tx_busy_in) begin
`ifdef MEM_BRIDGE_CHECKSUM_EN
                        if (r_cks_phase)       w_next = S_DONE;
                        else if (!w_last_byte) w_next = S_SEND;
                        else if (w_last_word)  w_next = S_SEND;
                        else                   w_next = S_FETCH;
`else
                        if (!w_last_byte)      w_next = S_SEND;
                        else if (w_last_word)  w_next = S_DONE;
                        else                   w_next = S_FETCH;
`endif
                    end
                end
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rd_addr   <= '0;
            r_lat       <= '0;
            r_shift     <= '0;
            r_byte_idx  <= '0;
            r_words     <= '0;
            r_ack_first <= 1'b0;
`ifdef MEM_BRIDGE_CHECKSUM_EN
            r_dump_xor  <= '0;
            r_cks_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rd_addr <= '0;
                    r_lat     <= '0;
                    r_words   <= '0;
`ifdef MEM_BRIDGE_CHECKSUM_EN
                    r_dump_xor  <= '0;
                    r_cks_phase <= 1'b0;
`endif
                end
                S_FETCH: begin
                    r_lat <= r_lat + 1'b1;
                    if (w_next == S_SEND) begin
                        r_shift    <= rd_data_in;
                        r_byte_idx <= '0;
                    end
                end
                S_SEND: begin
                    if (w_trigger) begin
                        r_ack_first <= 1'b1;
`ifdef MEM_BRIDGE_CHECKSUM_EN
                        r_dump_xor  <= r_dump_xor ^ r_shift[7:0];
`endif
                    end
                end
                S_ACK: begin
                    r_ack_first <= 1'b0;
                    if (w_next == S_SEND) begin
`ifdef MEM_BRIDGE_CHECKSUM_EN
                        if (w_last_byte) begin
                            r_shift     <= WORD_WIDTH'(r_dump_xor);
                            r_cks_phase <= 1'b1;
                        end else
`endif
                        begin
                            r_shift    <= r_shift >> 8;
                            r_byte_idx <= r_byte_idx + 1'b1;
                        end
                    end else if (w_next == S_FETCH) begin
                        r_rd_addr <= r_rd_addr + 1'b1;
                        r_words   <= r_words + 1'b1;
                        r_lat     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign load_count_out = r_load_count;
    assign overflow_out   = r_overflow;
    assign rd_addr_out    = r_rd_addr;
    assign tx_byte_out    = r_shift[7:0];
    assign tx_trigger_out = w_trigger;
    assign dump_done_out  = (r_state == S_DONE);
endmodule

// File: tb/tb_mem_stream_bridge.sv
// tb/tb_mem_stream_bridge.sv - self-checking bench for mem_stream_bridge (WORD_WIDTH=32, DEPTH=4)
`timescale 1ns/1ps
module tb_mem_stream_bridge;
    localparam int WW = 32;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int RL = 2;

    logic          clk_in = 1'b0;
    logic          rst_in, dump_en_in, rx_valid_in, tx_busy_in;
    logic [AW:0]   dump_len_in;
    logic [7:0]    rx_byte_in;
    logic          wr_en_out, tx_trigger_out, overflow_out, dump_done_out;
    logic [AW-1:0] wr_addr_out, rd_addr_out;
    logic [WW-1:0] wr_data_out, rd_data_in;
    logic [7:0]    tx_byte_out;
    logic [AW:0]   load_count_out;
`ifdef MEM_BRIDGE_CHECKSUM_EN
    logic [7:0]    checksum_out;
`endif

    always #5 clk_in = ~clk_in;

    mem_stream_bridge #(.WORD_WIDTH(WW), .DEPTH(DP), .ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .dump_en_in(dump_en_in), .dump_len_in(dump_len_in),
        .rx_valid_in(rx_valid_in), .rx_byte_in(rx_byte_in), .wr_en_out(wr_en_out),
        .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .rd_addr_out(rd_addr_out),
        .rd_data_in(rd_data_in), .tx_byte_out(tx_byte_out), .tx_trigger_out(tx_trigger_out),
        .tx_busy_in(tx_busy_in), .load_count_out(load_count_out), .overflow_out(overflow_out),
`ifdef MEM_BRIDGE_CHECKSUM_EN
        .checksum_out(checksum_out),
`endif
        .dump_done_out(dump_done_out));

    // BRAM with RL-cycle registered read
    logic          mem_clear;
    logic [WW-1:0] mem [DP];
    logic [WW-1:0] rd_pipe [RL];
    always @(posedge clk_in) begin
        if (mem_clear) for (int i = 0; i < DP; i++) mem[i] <= '0;
        else if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
        rd_pipe[0] <= mem[rd_addr_out];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rd_data_in = rd_pipe[RL-1];

    typedef struct packed { logic [AW-1:0] a; logic [WW-1:0] d; } wr_t;
    wr_t        wr_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] stim_q[$];
    int busy_viol = 0, consec_viol = 0, wr_consec = 0;
    logic prev_trig = 1'b0, prev_wr = 1'b0;
    always @(negedge clk_in) begin
        if (tx_trigger_out) begin
            tx_q.push_back(tx_byte_out);
            if (tx_busy_in) busy_viol++;
            if (prev_trig) consec_viol++;
        end
        if (wr_en_out) begin
            wr_q.push_back({wr_addr_out, wr_data_out});
            if (prev_wr) wr_consec++;
        end
        prev_trig = tx_trigger_out;
        prev_wr   = wr_en_out;
    end

    // Transmitter: raises busy the cycle after a trigger and holds it busy_len cycles
    int busy_len = 0;
    initial begin
        tx_busy_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (tx_trigger_out && busy_len > 0) begin
                @(posedge clk_in); #1 tx_busy_in = 1'b1;
                repeat (busy_len) @(posedge clk_in);
                #1 tx_busy_in = 1'b0;
            end
        end
    end

    int tests = 0, fails = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid_in = 1'b1; rx_byte_in = b;
        @(posedge clk_in); #1 rx_valid_in = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    logic [WW-1:0] mdl_mem [DP];
    int            mdl_count;
    bit            mdl_ovf;
    logic [7:0]    mdl_xor;

    task automatic mdl_restart();
        mdl_count = 0; mdl_ovf = 0; mdl_xor = 8'h00;
    endtask

    // Every complete group of four bytes becomes one little-endian word at the next free address.
    task automatic load_and_check(input string tag, input int maxgap);
        wr_t exp_q[$];
        wr_t e;
        int n;
        n = stim_q.size();
        wr_q.delete();
        for (int i = 0; i < n; i++) begin
            mdl_xor ^= stim_q[i];
            send_byte(stim_q[i], int'($urandom_range(0, maxgap)));
        end
        for (int i = 0; i + 3 < n; i += 4) begin
            e.d = {stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
            if (mdl_count == DP) mdl_ovf = 1;
            else begin
                e.a = AW'(mdl_count);
                mdl_mem[mdl_count] = e.d;
                exp_q.push_back(e);
                mdl_count++;
            end
        end
        tick(3);
        check({tag, "_nwrites"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check({tag, "_addr"}, wr_q[i].a, exp_q[i].a);
            check({tag, "_data"}, wr_q[i].d, exp_q[i].d);
        end
        check({tag, "_count"}, load_count_out, mdl_count);
        check({tag, "_ovf"}, overflow_out, mdl_ovf);
`ifdef MEM_BRIDGE_CHECKSUM_EN
        check({tag, "_cks"}, checksum_out, mdl_xor);
`endif
        stim_q.delete();
    endtask

    task automatic run_dump(input string tag, input logic [AW:0] len, input int busy,
                            input int words, input bit noise);
        logic [7:0] exp_q[$];
        logic [7:0] x;
        int t;
        x = 8'h00;
        for (int w = 0; w < words; w++)
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(mdl_mem[w][8*b +: 8]);
                x ^= mdl_mem[w][8*b +: 8];
            end
`ifdef MEM_BRIDGE_CHECKSUM_EN
        exp_q.push_back(x);
`endif
        tx_q.delete(); wr_q.delete();
        busy_len = busy; dump_len_in = len; dump_en_in = 1'b1;
        if (noise) for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0);
        t = 0;
        while (!dump_done_out && t < 3000) begin tick(1); t++; end
        check({tag, "_done"}, dump_done_out, 1);
        tick(2);
        check({tag, "_nbytes"}, tx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
            check({tag, "_byte"}, tx_q[i], exp_q[i]);
        check({tag, "_nowrite"}, wr_q.size(), 0);
        check({tag, "_hold_cnt"}, load_count_out, mdl_count);
        check({tag, "_hold_ovf"}, overflow_out, mdl_ovf);
        dump_en_in = 1'b0;
        mdl_restart();
        tick(1);
        check({tag, "_done_clr"}, dump_done_out, 0);
        check({tag, "_restart"}, load_count_out, mdl_count);
        check({tag, "_ovf_clr"}, overflow_out, mdl_ovf);
    endtask

    typedef struct packed { logic [7:0] b0, b1, b2, b3; logic [WW-1:0] word; } load_vec_t;
    typedef struct packed { logic [AW:0] len; logic [3:0] words; } len_vec_t;
    load_vec_t load_tbl [4];
    len_vec_t  len_tbl [7];

    initial begin
        int t;
        int eff;
        logic [AW:0] rl;
        rst_in = 1'b1; dump_en_in = 1'b0; dump_len_in = '0; rx_valid_in = 1'b0; rx_byte_in = 8'h00;
        mem_clear = 1'b1;
        for (int i = 0; i < DP; i++) mdl_mem[i] = '0;
        mdl_restart();
        load_tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
        load_tbl[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA};
        load_tbl[2] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
        load_tbl[3] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201};
        len_tbl[0] = '{3'd2, 4'd2};
        len_tbl[1] = '{3'd0, 4'd4};
        len_tbl[2] = '{3'd1, 4'd1};
        len_tbl[3] = '{3'd4, 4'd4};
        len_tbl[4] = '{3'd5, 4'd4};
        len_tbl[5] = '{3'd7, 4'd4};
        len_tbl[6] = '{3'd3, 4'd3};

        tick(3);
        check("rst_wr_en", wr_en_out, 0);
        check("rst_count", load_count_out, 0);
        check("rst_ovf", overflow_out, 0);
        check("rst_trigger", tx_trigger_out, 0);
        check("rst_done", dump_done_out, 0);
        check("rst_busvals", {wr_addr_out, wr_data_out, rd_addr_out, tx_byte_out}, 0);
        rst_in = 1'b0; mem_clear = 1'b0;
        tick(1);

        for (int r = 0; r < 4; r++) begin
            stim_q = {load_tbl[r].b0, load_tbl[r].b1, load_tbl[r].b2, load_tbl[r].b3};
            load_and_check($sformatf("load%0d", r), 2);
            if (wr_q.size() > 0) check($sformatf("load%0d_tbl", r), wr_q[0].d, load_tbl[r].word);
`ifdef MEM_BRIDGE_CHECKSUM_EN
            if (r == 0) check("load_cks_44", checksum_out, 8'h44);
`endif
        end

        stim_q = {8'h55, 8'h66, 8'h77, 8'h88};
        load_and_check("ovf", 1);
        check("ovf_flag", overflow_out, 1);
        check("ovf_count", load_count_out, 4);

        run_dump("dump2", 3'd2, 10, 2, 1'b1);
        for (int i = 0; i < 7; i++)
            run_dump($sformatf("len%0d", len_tbl[i].len), len_tbl[i].len, (i % 2) * 3,
                     int'(len_tbl[i].words), 1'b0);

        tx_q.delete(); busy_len = 10; dump_len_in = '0; dump_en_in = 1'b1;
        t = 0;
        while (tx_q.size() < 3 && t < 2000) begin tick(1); t++; end
        check("abort_reach3", tx_q.size() >= 3, 1);
        dump_en_in = 1'b0;
        mdl_restart();
        tick(40);
        check("abort_no_more", tx_q.size(), 3);
        check("abort_done_low", dump_done_out, 0);
        for (int i = 0; i < 3 && i < tx_q.size(); i++)
            check("abort_byte", tx_q[i], mdl_mem[0][8*i +: 8]);
        for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
        load_and_check("abort_load", 1);
        if (wr_q.size() > 0) check("abort_addr0", wr_q[0].a, 0);

        for (int i = 0; i < 4; i++) stim_q.push_back(8'($urandom));
        load_and_check("pre_rst", 1);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 1);
        #2 rst_in = 1'b1;
        #1;
        check("rstpack_count", load_count_out, 0);
        check("rstpack_wr_en", wr_en_out, 0);
        check("rstpack_wr_data", wr_data_out, 0);
`ifdef MEM_BRIDGE_CHECKSUM_EN
        check("rstpack_cks", checksum_out, 0);
`endif
        @(posedge clk_in); #1 rst_in = 1'b0;
        mdl_restart();
        tick(1);
        stim_q = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
        load_and_check("post_rst", 2);
        if (wr_q.size() > 0) check("post_rst_addr0", wr_q[0].a, 0);

        tx_q.delete(); busy_len = 3; dump_len_in = '0; dump_en_in = 1'b1;
        t = 0;
        while (t < 2000) begin
            @(negedge clk_in);
            if (tx_trigger_out && tx_q.size() >= 4) break;
            t++;
        end
        check("rstdump_trig_seen", tx_trigger_out, 1);
        #1 rst_in = 1'b1;
        #1;
        check("rstdump_trigger", tx_trigger_out, 0);
        check("rstdump_rd_addr", rd_addr_out, 0);
        check("rstdump_tx_byte", tx_byte_out, 0);
        check("rstdump_done", dump_done_out, 0);
        dump_en_in = 1'b0;
        @(posedge clk_in); #1 rst_in = 1'b0;
        mdl_restart();
        t = 0;
        while (tx_busy_in && t < 100) begin tick(1); t++; end
        tick(2);
        check("rstdump_no_trig", tx_q.size() <= 6, 1);
        stim_q = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
        load_and_check("post_rstdump", 1);
        if (wr_q.size() > 0) check("post_rstdump_addr0", wr_q[0].a, 0);

        for (int it = 0; it < 12; it++) begin
            int nb;
            nb = 4 * int'($urandom_range(1, 5)) + int'($urandom_range(0, 3));
            for (int k = 0; k < nb; k++) stim_q.push_back(8'($urandom));
            load_and_check($sformatf("rnd%0d_load", it), 2);
            rl = AW'(0) + 3'($urandom_range(0, 7));
            eff = (rl == 0 || rl > DP) ? DP : int'(rl);
            run_dump($sformatf("rnd%0d_dump", it), rl, int'($urandom_range(0, 4)), eff, it[0]);
        end

        check("trig_while_busy", busy_viol, 0);
        check("trig_back_to_back", consec_viol, 0);
        check("wr_en_multi_cycle", wr_consec, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_stream_bridge.md
Name: mem_stream_bridge

Overview:
- Parametrised byte-stream ↔ word-memory bridge that sits between the UART receive/transmit pair and a block of word-wide BRAM.
- Load mode: packs incoming bytes little-endian into WORD_WIDTH words and writes them to sequential addresses.
- Dump mode: reads words back, unpacks them LSB-first and sends them over a trigger/busy handshake with correct back-pressure.
- Replaces the fixed 4-byte pack and free-running dump loop with generalised width, depth, read latency and length control.

Parameters:
- WORD_WIDTH, 32, memory word width in bits; must be a multiple of 8; BPW = WORD_WIDTH/8.
- DEPTH, 25251, number of words in the addressed space.
- ADDR_WIDTH, $clog2(DEPTH), memory address width.
- READ_LATENCY, 2, cycles from rd_addr_out change to valid rd_data_in (2 = HIGH_PERFORMANCE BRAM).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset.
- dump_en_in  input  1  level: 1 = dump mode, 0 = load mode.
- dump_len_in  input  ADDR_WIDTH+1  words to dump; 0 or >DEPTH means DEPTH.
- rx_valid_in  input  1  one-cycle strobe, rx_byte_in valid.
- rx_byte_in  input  8  received byte.
- wr_en_out  output  1  memory write strobe.
- wr_addr_out  output  ADDR_WIDTH  write address.
- wr_data_out  output  WORD_WIDTH  packed write word.
- rd_addr_out  output  ADDR_WIDTH  read address.
- rd_data_in  input  WORD_WIDTH  read data.
- tx_byte_out  output  8  byte to transmitter.
- tx_trigger_out  output  1  one-cycle send strobe.
- tx_busy_in  input  1  transmitter busy.
- load_count_out  output  ADDR_WIDTH+1  words written since reset/last load restart.
- overflow_out  output  1  sticky: a word was dropped because memory was full.
- dump_done_out  output  1  dump finished; held until dump_en_in falls.

Behaviour:
- Clock clk_in; reset rst_in asynchronous, active-high.
- Reset values: all outputs 0, byte index 0, state IDLE.
- Load (dump_en_in=0):
  - Each rx_valid_in shifts rx_byte_in into byte lane idx; byte 0 goes to bits [7:0].
  - When idx reaches BPW-1, the next cycle gives wr_en_out=1 for exactly one cycle, with wr_addr_out = load_count_out (pre-increment) and wr_data_out = the packed word. load_count_out then increments and idx clears.
  - Latency: last byte strobe to wr_en_out is 1 cycle.
  - Full: if load_count_out == DEPTH, the completed word is not written (wr_en_out stays 0), overflow_out sets, and the count saturates.
  - A byte strobe arriving in the same cycle as the write pulse is accepted into lane 0.
- Entering dump (dump_en_in 0→1):
  - The partial pack is discarded (idx=0).
  - Bytes received while dump_en_in=1 are ignored.
  - load_count_out and overflow_out are held.
- Dump FSM states:
  - IDLE: dump_en_in=1 → FETCH, read address 0.
  - FETCH: drive rd_addr_out, count READ_LATENCY cycles, latch rd_data_in into the shift register → SEND.
  - SEND: when tx_busy_in=0, pulse tx_trigger_out with tx_byte_out = current low byte → ACK.
  - ACK: wait 1 cycle (transmitter registers busy), then wait for tx_busy_in=0.
    - More bytes in the word → SEND with the word shifted right by 8.
    - Else word count+1 == effective length → DONE.
    - Else → FETCH with address+1.
  - DONE: dump_done_out=1; dump_en_in=0 → IDLE, dump_done_out=0.
- Abort: dump_en_in falling in any dump state → IDLE on the next edge.
  - tx_trigger_out is never asserted after the abort.
  - A byte already triggered completes in the transmitter.
- Re-entering load after a dump restarts load_count_out at 0 and clears overflow_out.
- tx_trigger_out is never high for two consecutive cycles and never high while tx_busy_in=1.
- Reset mid-operation forces all state and outputs to their reset values immediately.

Optional Feature:
- Macro: MEM_BRIDGE_CHECKSUM_EN.
- Defined:
  - After the last data byte, an extra byte is sent via SEND/ACK before DONE.
  - Its value is the XOR of all dump bytes sent.
  - The load path also XORs every accepted byte; the running value is exposed on extra output checksum_out[7:0], reset 0 and cleared when a load restarts.
- Undefined: no checksum logic, no checksum_out port, DONE follows the last data byte directly.

Test Plan:
- Load: WORD_WIDTH=32, DEPTH=4; bytes 0x11,0x22,0x33,0x44 → single wr_en_out at addr 0, data 0x44332211, load_count_out=1.
- Overflow: 20 bytes into DEPTH=4 → writes at addr 0..3 only, 5th word dropped, overflow_out=1, load_count_out=4.
- Dump: memory preloaded {0x44332211, 0xDDCCBBAA}, dump_len_in=2, tx_busy_in high 10 cycles after each trigger → bytes 11,22,33,44,AA,BB,CC,DD in order, no trigger while busy, then dump_done_out=1.
- Abort: dump_en_in dropped after the 3rd trigger → no further triggers, state IDLE, next load writes addr 0.
- Reset: rst_in asserted mid-pack (2 bytes in) and mid-dump → outputs 0 asynchronously; after release, 4 new bytes produce one write at addr 0.
- Checksum (MEM_BRIDGE_CHECKSUM_EN): dump of 0x44332211 → 11,22,33,44 then 0x44; checksum_out after loading the same bytes = 0x44.
